// File: rtl/ext_com_link_ctrl.sv
// ext_com_link_ctrl: send/ACK-retry and get/ACK sequencer for the two ext-com UART channels
module ext_com_link_ctrl #(
  parameter int UART_WIDTH = 8,
  parameter logic [UART_WIDTH-1:0] UART_ACK = 8'hCC,
  parameter int RETRANSMIT_COUNT = 5,
  parameter int CLK_FREQ = 50000000,
  parameter int ACK_TIMEOUT = 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  enable,
  input  logic [UART_WIDTH-1:0] send_value,
  input  logic                  send_req,
  output logic                  send_busy,
  output logic                  send_done,
  output logic                  send_fail,
  output logic [2:0]            retry_cnt,
  output logic [UART_WIDTH-1:0] s_tx_data,
  output logic                  s_tx_valid,
  input  logic                  s_tx_ready,
  input  logic [UART_WIDTH-1:0] s_rx_data,
  input  logic                  s_rx_valid,
  input  logic [UART_WIDTH-1:0] g_rx_data,
  input  logic                  g_rx_valid,
  output logic [UART_WIDTH-1:0] got_value,
  output logic                  got_valid,
  output logic                  g_overrun,
  output logic [UART_WIDTH-1:0] g_tx_data,
  output logic                  g_tx_valid,
  input  logic                  g_tx_ready
);
  localparam int TO_CYC = CLK_FREQ / 1000 * ACK_TIMEOUT;
  localparam int TW = $clog2(TO_CYC + 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} s_state_t;
  typedef enum logic {G_IDLE, G_ACK} g_state_t;
  s_state_t s_state, s_nxt;
  g_state_t g_state, g_nxt;
  logic [TW-1:0] timer;
  logic s_start, s_ack, s_tout, s_retry, s_giveup, g_take, g_drop;
  assign g_tx_data = UART_ACK;
  always_comb begin
    s_start = enable && s_state == S_IDLE && send_req;
    s_ack = enable && s_state == S_WAIT && s_rx_valid && s_rx_data == UART_ACK;
    s_tout = enable && s_state == S_WAIT && !s_ack && timer == TW'(TO_CYC - 1);
    s_retry = s_tout && retry_cnt < 3'(RETRANSMIT_COUNT);
    s_giveup = s_tout && !s_retry;
    g_take = enable && g_state == G_IDLE && g_rx_valid;
    g_drop = enable && g_state == G_ACK && g_rx_valid;
    s_nxt = S_IDLE;
    case (s_state)
      S_IDLE:  s_nxt = s_start ? S_LOAD : S_IDLE;
      S_LOAD:  s_nxt = s_tx_ready ? S_WAIT : S_LOAD;
      S_WAIT:  s_nxt = s_ack || s_giveup ? S_IDLE : s_retry ? S_LOAD : S_WAIT;
      default: s_nxt = S_IDLE;
    endcase
    if (!enable) s_nxt = S_IDLE;
    g_nxt = !enable ? G_IDLE : g_state == G_IDLE ? (g_take ? G_ACK : G_IDLE) : (g_tx_ready ? G_IDLE : G_ACK);
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s_state <= S_IDLE;
      g_state <= G_IDLE;
      timer <= '0;
      retry_cnt <= '0;
      s_tx_data <= '0;
      s_tx_valid <= 1'b0;
      send_busy <= 1'b0;
      send_done <= 1'b0;
      send_fail <= 1'b0;
      got_value <= '0;
      got_valid <= 1'b0;
      g_overrun <= 1'b0;
      g_tx_valid <= 1'b0;
    end else begin
      s_state <= s_nxt;
      g_state <= g_nxt;
      timer <= s_state == S_WAIT && s_nxt == S_WAIT ? timer + 1'b1 : '0;
      retry_cnt <= s_start ? 3'd0 : s_retry ? retry_cnt + 3'd1 : retry_cnt;
      s_tx_data <= s_start ? send_value : s_tx_data;
      s_tx_valid <= s_nxt == S_LOAD;
      send_busy <= s_nxt != S_IDLE;
      send_done <= s_ack;
      send_fail <= s_giveup;
      got_value <= g_take ? g_rx_data : got_value;
      got_valid <= g_take;
      g_overrun <= g_drop;
      g_tx_valid <= g_nxt == G_ACK;
    end
  end
endmodule

// File: tb/tb_ext_com_link_ctrl.sv
// tb_ext_com_link_ctrl: scoreboard bench for the ext-com send/get link controller
module tb_ext_com_link_ctrl;
  logic clk = 1'b0;
  logic rstN, enable, send_req, send_busy, send_done, send_fail;
  logic s_tx_valid, s_tx_ready, s_rx_valid, g_rx_valid, got_valid, g_overrun, g_tx_valid, g_tx_ready;
  logic [2:0] retry_cnt;
  logic [7:0] send_value, s_tx_data, s_rx_data, g_rx_data, got_value, g_tx_data;
  logic tx_auto, g_auto;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_stx[$];
  logic [7:0] exp_got[$];
  logic [7:0] exp_gtx[$];
  logic [7:0] exp_ovr[$];
  logic [2:0] exp_done[$];
  logic [2:0] exp_fail[$];
  int stx_cyc[$];
  ext_com_link_ctrl #(
    .UART_WIDTH(8), .UART_ACK(8'hCC), .RETRANSMIT_COUNT(2), .CLK_FREQ(1000000), .ACK_TIMEOUT(1)
  ) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .send_value(send_value), .send_req(send_req),
    .send_busy(send_busy), .send_done(send_done), .send_fail(send_fail), .retry_cnt(retry_cnt),
    .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
    .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid), .g_rx_data(g_rx_data), .g_rx_valid(g_rx_valid),
    .got_value(got_value), .got_valid(got_valid), .g_overrun(g_overrun),
    .g_tx_data(g_tx_data), .g_tx_valid(g_tx_valid), .g_tx_ready(g_tx_ready)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value %0h, none expected", name, act);
  endtask
  task automatic drained(input string t);
    chk({t, " s_tx left"}, exp_stx.size(), 0);
    chk({t, " done left"}, exp_done.size(), 0);
    chk({t, " fail left"}, exp_fail.size(), 0);
    chk({t, " got left"}, exp_got.size(), 0);
    chk({t, " g_tx left"}, exp_gtx.size(), 0);
    chk({t, " ovr left"}, exp_ovr.size(), 0);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial forever begin
    @(negedge clk);
    s_tx_ready = tx_auto && s_tx_valid && !s_tx_ready;
    g_tx_ready = g_auto && g_tx_valid && !g_tx_ready;
  end
  initial forever begin
    @(negedge clk);
    #3;
    if (s_tx_valid === 1'b1 && s_tx_ready === 1'b1) begin
      stx_cyc.push_back(cyc);
      if (exp_stx.size() == 0) unexpected("s_tx", s_tx_data);
      else chk("s_tx_data", s_tx_data, exp_stx.pop_front());
    end
    if (send_done === 1'b1) begin
      chk("busy at done", send_busy, 0);
      if (exp_done.size() == 0) unexpected("send_done", retry_cnt);
      else chk("retry at done", retry_cnt, exp_done.pop_front());
    end
    if (send_fail === 1'b1) begin
      chk("busy at fail", send_busy, 0);
      if (exp_fail.size() == 0) unexpected("send_fail", retry_cnt);
      else chk("retry at fail", retry_cnt, exp_fail.pop_front());
    end
    if (got_valid === 1'b1) begin
      if (exp_got.size() == 0) unexpected("got_valid", got_value);
      else chk("got_value", got_value, exp_got.pop_front());
    end
    if (g_tx_valid === 1'b1 && g_tx_ready === 1'b1) begin
      if (exp_gtx.size() == 0) unexpected("g_tx", g_tx_data);
      else chk("g_tx_data", g_tx_data, exp_gtx.pop_front());
    end
    if (g_overrun === 1'b1) begin
      if (exp_ovr.size() == 0) unexpected("g_overrun", got_value);
      else chk("got at overrun", got_value, exp_ovr.pop_front());
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rstN = 1'b0;
    enable = 1'b0;
    send_req = 1'b0;
    send_value = '0;
    s_rx_data = '0;
    s_rx_valid = 1'b0;
    g_rx_data = '0;
    g_rx_valid = 1'b0;
    s_tx_ready = 1'b0;
    g_tx_ready = 1'b0;
    tx_auto = 1'b1;
    g_auto = 1'b1;
    step(3);
    rstN = 1'b1;
    enable = 1'b1;
    step(1);
    chk("rst s_tx_valid", s_tx_valid, 0);
    chk("rst send_busy", send_busy, 0);
    chk("rst pulses", {send_done, send_fail, got_valid, g_overrun}, 0);
    chk("rst retry_cnt", retry_cnt, 0);
    chk("rst got_value", got_value, 0);
    chk("rst s_tx_data", s_tx_data, 0);
    chk("rst g_tx_valid", g_tx_valid, 0);
    chk("rst g_tx_data", g_tx_data, 8'hCC);
    exp_stx.push_back(8'h05);
    exp_done.push_back(3'd0);
    send_value = 8'h05;
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
    step(51);
    s_rx_data = 8'hCC;
    s_rx_valid = 1'b1;
    step(1);
    s_rx_valid = 1'b0;
    step(3);
    chk("t1 busy", send_busy, 0);
    chk("t1 retry", retry_cnt, 0);
    drained("t1");
    stx_cyc.delete();
    repeat (3) exp_stx.push_back(8'h3B);
    exp_fail.push_back(3'd2);
    send_value = 8'h3B;
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
    step(3100);
    chk("t2 busy", send_busy, 0);
    chk("t2 retry", retry_cnt, 2);
    chk("t2 transfers", stx_cyc.size(), 3);
    if (stx_cyc.size() == 3) begin
      chk("t2 gap1", stx_cyc[1] - stx_cyc[0], 1001);
      chk("t2 gap2", stx_cyc[2] - stx_cyc[1], 1001);
    end
    drained("t2");
    repeat (2) exp_stx.push_back(8'h2F);
    exp_done.push_back(3'd1);
    send_value = 8'h2F;
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
    step(99);
    s_rx_data = 8'hAA;
    s_rx_valid = 1'b1;
    step(1);
    s_rx_valid = 1'b0;
    step(999);
    s_rx_data = 8'hCC;
    s_rx_valid = 1'b1;
    step(1);
    s_rx_valid = 1'b0;
    step(5);
    chk("t3 busy", send_busy, 0);
    chk("t3 retry", retry_cnt, 1);
    drained("t3");
    g_auto = 1'b0;
    exp_got.push_back(8'h3F);
    g_rx_data = 8'h3F;
    g_rx_valid = 1'b1;
    step(1);
    g_rx_valid = 1'b0;
    step(4);
    exp_ovr.push_back(8'h3F);
    g_rx_data = 8'h11;
    g_rx_valid = 1'b1;
    step(1);
    g_rx_valid = 1'b0;
    step(2);
    chk("t4 g_tx held", g_tx_valid, 1);
    exp_gtx.push_back(8'hCC);
    g_auto = 1'b1;
    step(5);
    chk("t4 got_value", got_value, 8'h3F);
    chk("t4 g_tx idle", g_tx_valid, 0);
    drained("t4");
    exp_stx.push_back(8'h6D);
    exp_done.push_back(3'd0);
    send_value = 8'h6D;
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
    step(499);
    send_value = 8'h77;
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
    step(500);
    s_rx_data = 8'hCC;
    s_rx_valid = 1'b1;
    step(1);
    s_rx_valid = 1'b0;
    step(3);
    chk("t5 busy", send_busy, 0);
    chk("t5 retry", retry_cnt, 0);
    chk("t5 latched", s_tx_data, 8'h6D);
    drained("t5");
    g_auto = 1'b0;
    exp_stx.push_back(8'h5A);
    exp_got.push_back(8'h42);
    send_value = 8'h5A;
    send_req = 1'b1;
    g_rx_data = 8'h42;
    g_rx_valid = 1'b1;
    step(1);
    send_req = 1'b0;
    g_rx_valid = 1'b0;
    step(9);
    chk("t6 busy before", send_busy, 1);
    chk("t6 g_tx before", g_tx_valid, 1);
    enable = 1'b0;
    s_rx_data = 8'hCC;
    s_rx_valid = 1'b1;
    g_rx_data = 8'h55;
    g_rx_valid = 1'b1;
    step(1);
    s_rx_valid = 1'b0;
    g_rx_valid = 1'b0;
    chk("t6 busy off", send_busy, 0);
    chk("t6 s_tx off", s_tx_valid, 0);
    chk("t6 g_tx off", g_tx_valid, 0);
    step(2);
    chk("t6 retry hold", retry_cnt, 0);
    chk("t6 got hold", got_value, 8'h42);
    enable = 1'b1;
    g_auto = 1'b1;
    step(2);
    drained("t6");
    tx_auto = 1'b0;
    send_value = 8'h9A;
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
    step(2);
    chk("t6 load valid", s_tx_valid, 1);
    #2;
    rstN = 1'b0;
    #1;
    chk("t6 rst s_tx_valid", s_tx_valid, 0);
    chk("t6 rst busy", send_busy, 0);
    chk("t6 rst s_tx_data", s_tx_data, 0);
    chk("t6 rst got_value", got_value, 0);
    chk("t6 rst g_tx_data", g_tx_data, 8'hCC);
    step(1);
    rstN = 1'b1;
    tx_auto = 1'b1;
    step(3);
    chk("t6 post rst idle", {s_tx_valid, send_busy}, 0);
    drained("t6b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
